// File: rtl/store_buffer.sv
// Store buffer: DEPTH-entry FIFO queuing CPU stores toward data memory; an entry reaches the memory side the cycle after it is enqueued.
// Stalls a store into a full buffer; STORE_BUFFER_FWD_EN forwards loads from buffered stores, otherwise a load hitting a buffered word stalls.
module store_buffer #(
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       we,
   input  logic                       re,
   input  logic [31:0]                a,
   input  logic [31:0]                wd,
   output logic [31:0]                rd,
   output logic                       stall,
   output logic                       mem_valid,
   input  logic                       mem_ready,
   output logic [31:0]                mem_addr,
   output logic [31:0]                mem_wdata,
   output logic [31:0]                mem_raddr,
   input  logic [31:0]                mem_rdata,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       idle
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH) + 1;

   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [29:0]   addr_q [DEPTH];
   logic [29:0]   addr_d [DEPTH];
   logic [31:0]   data_q [DEPTH];
   logic [31:0]   data_d [DEPTH];
   logic          full;
   logic          enq;
   logic          deq;
   logic          hit;
`ifdef STORE_BUFFER_FWD_EN
   logic [31:0]   hit_data;
`endif

   // full uses the registered count, so a same-cycle drain cannot admit a store
   assign full      = (count_q == CW'(DEPTH));
   assign enq       = we & ~full;
   assign mem_valid = (count_q != '0);
   assign deq       = mem_valid & mem_ready;
   assign mem_addr  = {addr_q[rd_ptr_q], 2'b00};
   assign mem_wdata = data_q[rd_ptr_q];
   assign mem_raddr = a;
   assign count     = count_q;
   assign idle      = (count_q == '0);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      addr_d   = addr_q;
      data_d   = data_q;
      if (enq) begin
         addr_d[wr_ptr_q] = a[31:2];
         data_d[wr_ptr_q] = wd;
         wr_ptr_d         = wr_ptr_q + PW'(1);
      end
      if (deq) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end
      if (enq && !deq) begin
         count_d = count_q + CW'(1);
      end else if (deq && !enq) begin
         count_d = count_q - CW'(1);
      end
   end

   // Scan oldest to youngest so the last match seen is the youngest store
   always_comb begin
      logic [PW-1:0] idx;
      idx = '0;
      hit = 1'b0;
`ifdef STORE_BUFFER_FWD_EN
      hit_data = '0;
`endif
      for (int i = 0; i < DEPTH; i++) begin
         idx = rd_ptr_q + PW'(i);
         if ((CW'(i) < count_q) && (addr_q[idx] == a[31:2])) begin
            hit = 1'b1;
`ifdef STORE_BUFFER_FWD_EN
            hit_data = data_q[idx];
`endif
         end
      end
   end

`ifdef STORE_BUFFER_FWD_EN
   assign stall = we & full;
   assign rd    = (re & hit) ? hit_data : mem_rdata;
`else
   assign stall = (we & full) | (re & hit);
   assign rd    = mem_rdata;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      addr_q <= addr_d;
      data_q <= data_d;
   end
endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: directed scenarios plus a randomized run against a queue-based reference model.
module tb_store_buffer;
   localparam int DEPTH = 4;
`ifdef STORE_BUFFER_FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        we = 1'b0, re = 1'b0, mem_ready = 1'b0;
   logic [31:0] a = '0, wd = '0, mem_rdata = '0;
   logic [31:0] rd, mem_addr, mem_wdata, mem_raddr;
   logic        stall, mem_valid, idle;
   logic [$clog2(DEPTH):0] count;

   int n_cmp = 0;
   int n_err = 0;

   typedef struct {
      logic [29:0] addr;
      logic [31:0] data;
   } ent_t;
   ent_t mq[$];

   store_buffer #(.DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .we(we), .re(re), .a(a), .wd(wd), .rd(rd),
      .stall(stall), .mem_valid(mem_valid), .mem_ready(mem_ready),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_raddr(mem_raddr),
      .mem_rdata(mem_rdata), .count(count), .idle(idle)
   );

   always #5 clk = ~clk;

   // Reference model: a plain queue in program order; head drains, tail receives.
   task automatic model_update();
      int   sz;
      ent_t e;
      sz = mq.size();
      if (reset) begin
         mq.delete();
      end else begin
         e.addr = a[31:2];
         e.data = wd;
         if (sz != 0 && mem_ready) mq.delete(0);
         if (we && sz < DEPTH) mq.push_back(e);
      end
   endtask

   function automatic logic model_hit(input logic [31:0] addr);
      model_hit = 1'b0;
      foreach (mq[i]) if (mq[i].addr == addr[31:2]) model_hit = 1'b1;
   endfunction

   function automatic logic [31:0] model_hit_data(input logic [31:0] addr);
      model_hit_data = '0;
      foreach (mq[i]) if (mq[i].addr == addr[31:2]) model_hit_data = mq[i].data;
   endfunction

   function automatic logic exp_stall();
      exp_stall = (we && mq.size() == DEPTH) || (!FWD && re && model_hit(a));
   endfunction

   function automatic logic [31:0] exp_rd();
      exp_rd = (FWD && re && model_hit(a)) ? model_hit_data(a) : mem_rdata;
   endfunction

   task automatic tick();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic set_in(input logic w, input logic r, input logic [31:0] addr, input logic [31:0] data);
      we = w;
      re = r;
      a  = addr;
      wd = data;
   endtask

   task automatic do_reset();
      set_in(0, 0, 0, 0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      set_in(0, 0, 0, 0);
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      #1;
      n_cmp++; if (count !== 0) begin n_err++; $display("FAIL reset_count: got %0d want 0", count); end
      n_cmp++; if (idle !== 1'b1) begin n_err++; $display("FAIL reset_idle: got %b want 1", idle); end
      n_cmp++; if (mem_valid !== 1'b0) begin n_err++; $display("FAIL reset_mem_valid: got %b want 0", mem_valid); end
      n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %b want 0", stall); end
   endtask

   task automatic test_single_store();
      do_reset();
      mem_ready = 1'b1;
      set_in(1, 0, 32'h64, 32'd7);
      #1;
      n_cmp++; if (mem_valid !== 1'b0) begin n_err++; $display("FAIL single_no_bypass: got %b want 0", mem_valid); end
      tick();
      set_in(0, 0, 0, 0);
      #1;
      n_cmp++; if (mem_valid !== 1'b1) begin n_err++; $display("FAIL single_valid: got %b want 1", mem_valid); end
      n_cmp++; if (mem_addr !== 32'h64) begin n_err++; $display("FAIL single_addr: got %h want 00000064", mem_addr); end
      n_cmp++; if (mem_wdata !== 32'd7) begin n_err++; $display("FAIL single_wdata: got %h want 00000007", mem_wdata); end
      tick();
      n_cmp++; if (idle !== 1'b1) begin n_err++; $display("FAIL single_idle_after: got %b want 1", idle); end
   endtask

   task automatic test_fill_stall();
      logic [31:0] got[$];
      logic [31:0] exp_order[5];
      exp_order = '{32'h10, 32'h14, 32'h18, 32'h1C, 32'h20};
      do_reset();
      mem_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         set_in(1, 0, 32'h10 + 32'(4 * i), 32'h100 + 32'(i));
         tick();
      end
      set_in(1, 0, 32'h20, 32'h104);
      #1;
      n_cmp++; if (count !== 4) begin n_err++; $display("FAIL fill_count: got %0d want 4", count); end
      n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL fill_stall_fifth: got %b want 1", stall); end
      tick();
      n_cmp++; if (count !== 4) begin n_err++; $display("FAIL fill_count_held: got %0d want 4", count); end
      mem_ready = 1'b1;
      for (int cyc = 0; cyc < 20; cyc++) begin
         logic accepted;
         #1;
         if (cyc == 0) begin
            n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL fill_stall_same_cycle_drain: got %b want 1", stall); end
         end
         if (mem_valid && mem_ready) got.push_back(mem_addr);
         accepted = we && !stall;
         tick();
         if (accepted) we = 1'b0;
         if (!mem_valid && !we) break;
      end
      n_cmp++; if (got.size() !== 5) begin n_err++; $display("FAIL drain_count: got %0d want 5", got.size()); end
      for (int i = 0; i < 5 && i < got.size(); i++) begin
         n_cmp++; if (got[i] !== exp_order[i]) begin n_err++; $display("FAIL drain_order[%0d]: got %h want %h", i, got[i], exp_order[i]); end
      end
   endtask

   task automatic test_full_stream();
      do_reset();
      mem_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         set_in(1, 0, 32'h200 + 32'(4 * i), $urandom);
         tick();
      end
      mem_ready = 1'b1;
      for (int j = 0; j < 12; j++) begin
         set_in(1, 0, 32'h300 + 32'(4 * j), $urandom);
         #1;
         n_cmp++; if (count !== mq.size()) begin n_err++; $display("FAIL stream_count: got %0d want %0d", count, mq.size()); end
         n_cmp++; if (stall !== exp_stall()) begin n_err++; $display("FAIL stream_stall: got %b want %b", stall, exp_stall()); end
         n_cmp++; if (mem_addr !== {mq[0].addr, 2'b00}) begin n_err++; $display("FAIL stream_addr: got %h want %h", mem_addr, {mq[0].addr, 2'b00}); end
         n_cmp++; if (mem_wdata !== mq[0].data) begin n_err++; $display("FAIL stream_wdata: got %h want %h", mem_wdata, mq[0].data); end
         tick();
      end
      set_in(0, 0, 0, 0);
      for (int k = 0; k < 10 && mq.size() != 0; k++) begin
         #1;
         n_cmp++; if (mem_addr !== {mq[0].addr, 2'b00}) begin n_err++; $display("FAIL stream_drain_addr: got %h want %h", mem_addr, {mq[0].addr, 2'b00}); end
         tick();
      end
      n_cmp++; if (idle !== 1'b1) begin n_err++; $display("FAIL stream_idle: got %b want 1", idle); end
   endtask

   task automatic test_forward();
      do_reset();
      mem_ready = 1'b0;
      set_in(1, 0, 32'h13AC, 32'h500);
      tick();
      set_in(1, 0, 32'h13AC, 32'hA00);
      tick();
      mem_rdata = 32'hDEADBEEF;
      set_in(0, 1, 32'h13AE, 0);
      #1;
      if (FWD) begin
         n_cmp++; if (rd !== 32'hA00) begin n_err++; $display("FAIL fwd_rd_youngest: got %h want 00000a00", rd); end
         n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL fwd_stall: got %b want 0", stall); end
      end else begin
         n_cmp++; if (rd !== 32'hDEADBEEF) begin n_err++; $display("FAIL nofwd_rd: got %h want deadbeef", rd); end
         n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL nofwd_stall: got %b want 1", stall); end
      end
      tick();
      mem_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         #1;
         n_cmp++; if (stall !== exp_stall()) begin n_err++; $display("FAIL load_hit_stall[%0d]: got %b want %b", k, stall, exp_stall()); end
         n_cmp++; if (rd !== exp_rd()) begin n_err++; $display("FAIL load_hit_rd[%0d]: got %h want %h", k, rd, exp_rd()); end
         tick();
      end
      n_cmp++; if (stall !== 1'b0 || rd !== 32'hDEADBEEF) begin n_err++; $display("FAIL load_after_drain: got stall=%b rd=%h want stall=0 rd=deadbeef", stall, rd); end
      mem_rdata = 32'h1234;
      set_in(1, 1, 32'h40, 32'h77);
      #1;
      n_cmp++; if (rd !== 32'h1234) begin n_err++; $display("FAIL same_cycle_no_fwd_rd: got %h want 00001234", rd); end
      n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL same_cycle_stall: got %b want 0", stall); end
      tick();
      set_in(0, 1, 32'h41, 0);
      #1;
      n_cmp++; if (rd !== (FWD ? 32'h77 : 32'h1234)) begin n_err++; $display("FAIL next_cycle_rd: got %h want %h", rd, FWD ? 32'h77 : 32'h1234); end
      n_cmp++; if (stall !== !FWD) begin n_err++; $display("FAIL next_cycle_stall: got %b want %b", stall, !FWD); end
      tick();
      set_in(0, 0, 0, 0);
      tick();
   endtask

   task automatic test_reset_mid();
      do_reset();
      mem_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         set_in(1, 0, 32'h500 + 32'(4 * i), $urandom);
         tick();
      end
      set_in(0, 0, 0, 0);
      #1;
      n_cmp++; if (count !== 3 || mem_valid !== 1'b1) begin n_err++; $display("FAIL midreset_pre: got count=%0d valid=%b want 3/1", count, mem_valid); end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      mem_ready = 1'b1;
      #1;
      n_cmp++; if (count !== 0) begin n_err++; $display("FAIL midreset_count: got %0d want 0", count); end
      n_cmp++; if (mem_valid !== 1'b0) begin n_err++; $display("FAIL midreset_valid: got %b want 0", mem_valid); end
      for (int k = 0; k < 5; k++) begin
         tick();
         n_cmp++; if (mem_valid !== 1'b0) begin n_err++; $display("FAIL midreset_no_write[%0d]: got %b want 0", k, mem_valid); end
      end
   endtask

   task automatic test_random();
      logic [31:0] ea;
      do_reset();
      for (int cyc = 0; cyc < 3000; cyc++) begin
         int op;
         op = $urandom_range(0, 3);
         ea = 32'h1000 + 32'(4 * $urandom_range(0, 5)) + 32'($urandom_range(0, 3));
         set_in(op == 1 || op == 3, op == 2, ea, $urandom);
         mem_ready = ($urandom_range(0, 2) != 0);
         mem_rdata = $urandom;
         reset = ($urandom_range(0, 199) == 0);
         #1;
         n_cmp++; if (count !== mq.size()) begin n_err++; $display("FAIL rnd_count@%0d: got %0d want %0d", cyc, count, mq.size()); end
         n_cmp++; if (idle !== (mq.size() == 0)) begin n_err++; $display("FAIL rnd_idle@%0d: got %b want %b", cyc, idle, mq.size() == 0); end
         n_cmp++; if (mem_valid !== (mq.size() != 0)) begin n_err++; $display("FAIL rnd_valid@%0d: got %b want %b", cyc, mem_valid, mq.size() != 0); end
         n_cmp++; if (stall !== exp_stall()) begin n_err++; $display("FAIL rnd_stall@%0d: got %b want %b", cyc, stall, exp_stall()); end
         n_cmp++; if (rd !== exp_rd()) begin n_err++; $display("FAIL rnd_rd@%0d: got %h want %h", cyc, rd, exp_rd()); end
         n_cmp++; if (mem_raddr !== ea) begin n_err++; $display("FAIL rnd_raddr@%0d: got %h want %h", cyc, mem_raddr, ea); end
         if (mq.size() != 0) begin
            n_cmp++; if (mem_addr !== {mq[0].addr, 2'b00}) begin n_err++; $display("FAIL rnd_addr@%0d: got %h want %h", cyc, mem_addr, {mq[0].addr, 2'b00}); end
            n_cmp++; if (mem_wdata !== mq[0].data) begin n_err++; $display("FAIL rnd_wdata@%0d: got %h want %h", cyc, mem_wdata, mq[0].data); end
         end
         tick();
      end
      reset = 1'b0;
      set_in(0, 0, 0, 0);
   endtask

   initial begin
      test_reset();
      test_single_store();
      test_fill_stall();
      test_full_stream();
      test_forward();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
